mod_n_updown_counter: RTL and testbench

Synchronous modulo-N up/down counter that produces the next-state count for the counter register bank. It counts on rising edges of a step strobe. It supports synchronous load, wrap or saturate at the bounds, a terminal-count flag, and sticky overflow/underflow flags. It is the stage directly upstream of the per-bit flip-flops and display decoders in the counter designs: its count output feeds the state/display path.

---
 rtl/mod_n_updown_counter_pkg.sv | 18 +
 rtl/mod_n_updown_counter_step_edge_detect.sv | 19 +
 rtl/mod_n_updown_counter.sv | 93 +++++++++
 tb/tb_mod_n_updown_counter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mod_n_updown_counter_pkg.sv
// rtl/mod_n_updown_counter_pkg.sv - shared counter constants and width helper
package mod_n_updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 0 + 1;

  // Decade counter defaults
  localparam int DEF_WIDTH = 4;
  localparam int DEF_MODULUS = 10;

  function automatic int min_width(input int modulus);
    int w;
    w = 1;
    while ((1 << w) < modulus) w++;
    return w;
  endfunction

endpackage

// File: rtl/mod_n_updown_counter_step_edge_detect.sv
// rtl/mod_n_updown_counter_step_edge_detect.sv - rising-edge pulse on a synchronous strobe
// History resets to 1 so a strobe held high through reset does not produce an edge.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic step_edge
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b1;
    else     step_q <= step;
  end

  assign step_edge = step & ~step_q;

endmodule

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - modulo-N up/down counter with load, wrap/saturate and sticky flags
import mod_n_updown_counter_pkg::*;

module mod_n_updown_counter #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             unf,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
  end

  // Compared in WIDTH bits so MODULUS == 2^WIDTH never overflows the constant
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic step_edge;

  step_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .step_edge (step_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= ZERO;
      wrap     <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap <= 1'b0;
      // Clear first so a same-cycle set below takes precedence
      if (clr_flags) begin
        ovf      <= 1'b0;
        unf      <= 1'b0;
        load_err <= 1'b0;
      end
      if (load) begin
        if (load_val > MAX_CNT) begin
          count    <= MAX_CNT;
          load_err <= 1'b1;
        end else begin
          count <= load_val;
        end
      end else if (en && step_edge) begin
        if (up) begin
          if (count == MAX_CNT) begin
            ovf <= 1'b1;
            if (SATURATE == MODE_WRAP) begin
              count <= ZERO;
              wrap  <= 1'b1;
            end
          end else begin
            count <= count + ONE;
          end
        end else begin
          if (count == ZERO) begin
            unf <= 1'b1;
            if (SATURATE == MODE_WRAP) begin
              count <= MAX_CNT;
              wrap  <= 1'b1;
            end
          end else begin
            count <= count - ONE;
          end
        end
      end
    end
  end

  assign tc = up ? (count == MAX_CNT) : (count == ZERO);

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - directed checks of wrap and saturate counter variants
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, step, up, load, clr_flags;
  logic [3:0] load_val;
  logic [3:0] count_w, count_s;
  logic       tc_w, wrap_w, ovf_w, unf_w, lerr_w;
  logic       tc_s, wrap_s, ovf_s, unf_s, lerr_s;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .step(step), .up(up), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(count_w), .tc(tc_w),
    .wrap(wrap_w), .ovf(ovf_w), .unf(unf_w), .load_err(lerr_w)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .step(step), .up(up), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(count_s), .tc(tc_s),
    .wrap(wrap_s), .ovf(ovf_s), .unf(unf_s), .load_err(lerr_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; step = 1'b1; up = 1'b1;
    load = 1'b0; load_val = 4'd0; clr_flags = 1'b0;
    cyc(); cyc();
    chk("rst_count_w", count_w, 0);
    chk("rst_wrap_w", wrap_w, 0);
    chk("rst_flags_w", {ovf_w, unf_w, lerr_w}, 0);
    chk("rst_count_s", count_s, 0);
    chk("rst_flags_s", {ovf_s, unf_s, lerr_s}, 0);

    // step held high across reset release must not count
    rst = 1'b0;
    cyc();
    chk("no_spurious", count_w, 0);
    step = 1'b0;
    cyc();

    for (int i = 1; i <= 10; i++) begin
      step = 1'b1;
      cyc();
      chk("up_count", count_w, i % 10);
      chk("up_wrap", wrap_w, (i == 10) ? 1 : 0);
      chk("up_tc", tc_w, (i == 9) ? 1 : 0);
      step = 1'b0;
      cyc();
      chk("wrap_clear", wrap_w, 0);
    end
    chk("ovf_w", ovf_w, 1);
    chk("sat_hold_count", count_s, 9);
    chk("sat_hold_wrap_ovf", {wrap_s, ovf_s}, 2'b01);

    up = 1'b0;
    step = 1'b1;
    cyc();
    chk("down_wrap_count", count_w, 9);
    chk("down_wrap_pulse", wrap_w, 1);
    chk("down_unf", unf_w, 1);
    chk("down_tc", tc_w, 0);
    step = 1'b0;
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("clr_flags_w", {ovf_w, unf_w}, 0);
    chk("clr_flags_s", ovf_s, 0);

    load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0; up = 1'b1; step = 1'b1;
    cyc();
    chk("sat_up_count", count_s, 9);
    chk("sat_up_ovf", ovf_s, 1);
    chk("sat_up_wrap", wrap_s, 0);
    step = 1'b0;
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0; up = 1'b0; step = 1'b1;
    cyc();
    chk("sat_dn_count", count_s, 0);
    chk("sat_dn_unf", unf_s, 1);
    chk("sat_dn_wrap", wrap_s, 0);
    step = 1'b0;

    load = 1'b1; load_val = 4'd12;
    cyc();
    chk("load_big_count", count_w, 9);
    chk("load_err", lerr_w, 1);

    // load beats a same-cycle step edge
    load_val = 4'd3; up = 1'b1; step = 1'b1;
    cyc();
    load = 1'b0;
    chk("load_step_count", count_w, 3);
    chk("load_step_wrap", wrap_w, 0);
    step = 1'b0;
    cyc();
    chk("load_step_after", count_w, 3);

    step = 1'b1;
    repeat (5) cyc();
    chk("held_step", count_w, 4);
    step = 1'b0;
    cyc();

    en = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    en = 1'b1;
    cyc(); cyc();
    chk("en_low_edge", count_w, 4);

    load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0;
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    chk("pre_rst_count", count_w, 7);
    chk("pre_rst_ovf", ovf_w, 1);
    rst = 1'b1; step = 1'b1;
    cyc();
    chk("mid_rst_count", count_w, 0);
    chk("mid_rst_flags", {wrap_w, ovf_w, unf_w, lerr_w}, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_count", count_w, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
